boss_projectile: RTL and testbench

//  Single boss projectile for the 200x300 VGA game. It launches from the boss position on a

---
 rtl/boss_proj_pkg.sv | 13 +
 rtl/boss_proj_box_overlap.sv | 31 +++
 rtl/boss_projectile.sv | 91 +++++++++
 tb/tb_boss_projectile.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/boss_proj_pkg.sv
// Shared constants and coordinate types for the boss projectile.
// The optional aim feature is enabled by defining BOSS_PROJ_AIM_EN.
package boss_proj_pkg;
  localparam int SCR_W_DEF = 200;
  localparam int SCR_H_DEF = 300;

  localparam logic [7:0] PROJ_R = 8'hFF;
  localparam logic [7:0] PROJ_G = 8'h40;
  localparam logic [7:0] PROJ_B = 8'h00;

  typedef logic [9:0] xcoord_t;
  typedef logic [8:0] ycoord_t;
endpackage

// File: rtl/boss_proj_box_overlap.sv
// Combinational axis-aligned rectangle overlap test between box A and box B.
// Sums are widened by one bit so edges near the coordinate limit cannot wrap.
module boss_proj_box_overlap
  import boss_proj_pkg::*;
#(
  parameter int AW = 4,
  parameter int AH = 4,
  parameter int BW = 10,
  parameter int BH = 10
) (
  input  xcoord_t ax,
  input  ycoord_t ay,
  input  xcoord_t bx,
  input  ycoord_t by,
  output logic    overlap
);
  logic [10:0] ax_w, bx_w, ax_end, bx_end;
  logic [9:0]  ay_w, by_w, ay_end, by_end;

  assign ax_w   = {1'b0, ax};
  assign bx_w   = {1'b0, bx};
  assign ay_w   = {1'b0, ay};
  assign by_w   = {1'b0, by};
  assign ax_end = ax_w + 11'(AW);
  assign bx_end = bx_w + 11'(BW);
  assign ay_end = ay_w + 10'(AH);
  assign by_end = by_w + 10'(BH);

  assign overlap = (ax_end > bx_w) && (ax_w < bx_end) &&
                   (ay_end > by_w) && (ay_w < by_end);
endmodule

// File: rtl/boss_projectile.sv
// Single leftward-travelling boss projectile with hit detection and pixel output.
// Define BOSS_PROJ_AIM_EN to make the projectile track the player vertically.
module boss_projectile
  import boss_proj_pkg::*;
#(
`ifdef BOSS_PROJ_AIM_EN
  parameter int SCR_H  = SCR_H_DEF,
  parameter int VSTEP  = 2,
`endif
  parameter int SIZE   = 4,
  parameter int STEP   = 4,
  parameter int CHAR_W = 10,
  parameter int CHAR_H = 10
) (
  input  logic       slow_clk,
  input  logic       reset,
  input  logic       fire,
  input  xcoord_t    start_x,
  input  ycoord_t    start_y,
  input  xcoord_t    x,
  input  ycoord_t    y,
  input  xcoord_t    char_x,
  input  ycoord_t    char_y,
  output logic       bullet_pix,
  output logic [7:0] bullet_r,
  output logic [7:0] bullet_g,
  output logic [7:0] bullet_b,
  output logic       bullet_hit
);
  logic    active;
  xcoord_t bx;
  ycoord_t by;
  logic    hit_now;

  boss_proj_box_overlap #(.AW(SIZE), .AH(SIZE), .BW(CHAR_W), .BH(CHAR_H)) u_hit (
    .ax(bx), .ay(by), .bx(char_x), .by(char_y), .overlap(hit_now)
  );

`ifdef BOSS_PROJ_AIM_EN
  // Step toward the player without overshooting, then clamp to the visible rows.
  localparam logic [9:0] YMAX = 10'(SCR_H - SIZE);
  ycoord_t    by_aim;
  logic [9:0] by_t;
  always_comb begin
    by_t = {1'b0, by};
    if (by < char_y) begin
      if (char_y - by < ycoord_t'(VSTEP)) by_t = {1'b0, char_y};
      else                                by_t = {1'b0, by} + 10'(VSTEP);
    end else if (by > char_y) begin
      if (by - char_y < ycoord_t'(VSTEP)) by_t = {1'b0, char_y};
      else                                by_t = {1'b0, by} - 10'(VSTEP);
    end
    by_aim = (by_t > YMAX) ? YMAX[8:0] : by_t[8:0];
  end
`endif

  always_ff @(posedge slow_clk or posedge reset) begin
    if (reset) begin
      active     <= 1'b0;
      bx         <= '0;
      by         <= '0;
      bullet_hit <= 1'b0;
    end else begin
      bullet_hit <= 1'b0;
      if (!active) begin
        if (fire) begin
          active <= 1'b1;
          bx     <= start_x;
          by     <= start_y;
        end
      end else if (hit_now) begin
        bullet_hit <= 1'b1;
        active     <= 1'b0;
      end else if (bx < xcoord_t'(STEP)) begin
        active <= 1'b0;
      end else begin
        bx <= bx - xcoord_t'(STEP);
`ifdef BOSS_PROJ_AIM_EN
        by <= by_aim;
`endif
      end
    end
  end

  assign bullet_pix = active &&
                      ({1'b0, x} >= {1'b0, bx}) && ({1'b0, x} < {1'b0, bx} + 11'(SIZE)) &&
                      ({1'b0, y} >= {1'b0, by}) && ({1'b0, y} < {1'b0, by} + 10'(SIZE));
  assign bullet_r = bullet_pix ? PROJ_R : 8'h00;
  assign bullet_g = bullet_pix ? PROJ_G : 8'h00;
  assign bullet_b = bullet_pix ? PROJ_B : 8'h00;
endmodule

// File: tb/tb_boss_projectile.sv
// Randomized and directed bench for boss_projectile against a behavioural model.
module tb_boss_projectile;
  logic       slow_clk = 0, reset = 1, fire = 0;
  logic [9:0] start_x = 0, x = 0, char_x = 0;
  logic [8:0] start_y = 0, y = 0, char_y = 0;
  logic       bullet_pix, bullet_hit;
  logic [7:0] bullet_r, bullet_g, bullet_b;

  boss_projectile dut (
    .slow_clk(slow_clk), .reset(reset), .fire(fire),
    .start_x(start_x), .start_y(start_y), .x(x), .y(y),
    .char_x(char_x), .char_y(char_y),
    .bullet_pix(bullet_pix), .bullet_r(bullet_r), .bullet_g(bullet_g),
    .bullet_b(bullet_b), .bullet_hit(bullet_hit)
  );

  always #10 slow_clk = ~slow_clk;

  int checks = 0, errors = 0;
  int m_act = 0, m_bx = 0, m_by = 0, m_hit = 0;
  int hit_seen = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_pix(input int px, input int py);
    return (m_act != 0 && px >= m_bx && px < m_bx + 4 && py >= m_by && py < m_by + 4) ? 1 : 0;
  endfunction

  // Probe a pixel and compare both the pixel flag and the colour to the model.
  task automatic probe(input string tag, input int px, input int py);
    int e;
    x = px[9:0]; y = py[8:0];
    #1;
    e = exp_pix(px, py);
    chk({tag, "_pix"}, bullet_pix, e);
    chk({tag, "_rgb"}, {bullet_r, bullet_g, bullet_b}, e ? 32'hFF4000 : 0);
  endtask

  task automatic pchk(input string tag, input int px, input int py, input int e);
    x = px[9:0]; y = py[8:0];
    #1;
    chk(tag, bullet_pix, e);
  endtask

  task automatic model_reset();
    m_act = 0; m_bx = 0; m_by = 0; m_hit = 0;
  endtask

  // Advance the model by one game tick using the inputs as they stand before the edge.
  task automatic tick();
    int cx, cy, d;
    cx = char_x; cy = char_y;
    if (reset) model_reset();
    else begin
      m_hit = 0;
      if (m_act == 0) begin
        if (fire) begin m_act = 1; m_bx = start_x; m_by = start_y; end
      end else if (m_bx + 4 > cx && m_bx < cx + 10 && m_by + 4 > cy && m_by < cy + 10) begin
        m_hit = 1; m_act = 0;
      end else if (m_bx < 4) begin
        m_act = 0;
      end else begin
        m_bx -= 4;
`ifdef BOSS_PROJ_AIM_EN
        d = cy - m_by;
        if (d < 2 && d > -2) m_by = cy;
        else m_by += (d > 0) ? 2 : -2;
        if (m_by > 296) m_by = 296;
`else
        d = 0;
`endif
      end
    end
    @(posedge slow_clk);
    #1;
    if (bullet_hit) hit_seen++;
    chk("hit", bullet_hit, m_hit);
    probe("trk", m_bx, m_by);
  endtask

  initial begin
    int n;
    // 1: reset holds everything off, fire during reset does nothing
    reset = 1; fire = 1; start_x = 180; start_y = 40;
    tick();
    pchk("rst_pix", 180, 40, 0);
    chk("rst_hit", bullet_hit, 0);
    chk("rst_rgb", {bullet_r, bullet_g, bullet_b}, 0);

    // 2: launch and pixel lookup
    reset = 0; fire = 1; char_x = 20; char_y = 200;
    tick();
    fire = 0;
    pchk("launch_in", 181, 41, 1);
    chk("launch_rgb", {bullet_r, bullet_g, bullet_b}, 32'hFF4000);
    pchk("launch_edge", 184, 41, 0);

    // 3: fly to the left edge, then vanish without a hit
    hit_seen = 0;
    for (int i = 0; i < 45; i++) tick();
    pchk("at_bx0", 0, 41, 1);
    tick();
    pchk("gone_left", 0, 41, 0);
    chk("no_hit_seen", hit_seen, 0);

    // 4: hit on the player at bx=108
    char_x = 100; char_y = 40; fire = 1;
    tick();
    fire = 0;
    n = 31;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (bullet_hit) begin n = i; break; end
    end
    chk("hit_tick", n, 19);
    tick();
    chk("hit_pulse_end", bullet_hit, 0);
    pchk("gone_hit", 108, 41, 0);

    // 5: fire held while active is ignored, relaunch afterwards
    char_x = 20; char_y = 200; fire = 1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    pchk("fire_ign", 160, 41, 1);
    start_x = 100;
    for (int i = 0; i < 40; i++) tick();
    tick();
    tick();
    pchk("relaunch", 100, 41, 1);
    fire = 0;

    // 6: asynchronous reset mid-flight
    reset = 1; tick(); reset = 0;
    start_x = 180; fire = 1; tick(); fire = 0;
    for (int i = 0; i < 10; i++) tick();
    pchk("pre_rst", 140, 41, 1);
    reset = 1; #1;
    model_reset();
    pchk("rst_mid", 140, 41, 0);
    chk("rst_mid_hit", bullet_hit, 0);
    #1 reset = 0;

`ifdef BOSS_PROJ_AIM_EN
    start_x = 180; start_y = 40; char_x = 20; char_y = 47; fire = 1;
    tick(); fire = 0;
    for (int i = 0; i < 5; i++) tick();
    pchk("aim_hold", m_bx, 47, 1);
`endif

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      fire = ($urandom % 4) == 0;
      if ($urandom % 40 == 0) begin
        char_x = 10'($urandom % 200);
        char_y = 9'($urandom % 300);
      end
      start_x = 10'($urandom % 220);
      if ($urandom % 2) start_y = 9'($urandom % 300);
      else start_y = 9'((int'(char_y) + 7 > 300) ? 290 : int'(char_y) + int'($urandom % 8));
      if ($urandom % 100 == 0) begin
        reset = 1; #1;
        model_reset();
        chk("rnd_rst_hit", bullet_hit, 0);
        #1 reset = 0;
      end
      tick();
      probe("rnd", m_bx + int'($urandom % 6) - 1, m_by + int'($urandom % 6) - 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
